// File: rtl/spi_ctrl_pkg.sv
// Shared types and constants for the round-robin SPI transaction scheduler.
package spi_ctrl_pkg;

  localparam int unsigned CMD_W     = 8;
  localparam int unsigned LEN_W     = 4;
  localparam int unsigned MAX_LEN   = 15;
  localparam int unsigned BUF_W     = 120;
  localparam int unsigned BIT_CNT_W = 7;

  // SPI mode 0: clock idles low, chip select idles high
  localparam logic SCLK_IDLE = 1'b0;
  localparam logic CS_N_IDLE = 1'b1;
  localparam logic MOSI_IDLE = 1'b0;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_SETUP = 3'd1,
    ST_CMD   = 3'd2,
    ST_DATA  = 3'd3,
    ST_HOLD  = 3'd4,
    ST_GAP   = 3'd5
  } state_e;

  typedef struct packed {
    logic [CMD_W-1:0] cmd;
    logic [LEN_W-1:0] len;
  } txn_t;

endpackage

// File: rtl/spi_bit_engine.sv
// SCLK divider, edge strobes, MOSI command shifter and MISO shift-in buffer.
module spi_bit_engine
  import spi_ctrl_pkg::*;
#(
  parameter int unsigned CLK_DIV = 10
) (
  input  logic             m_clk,
  input  logic             n_reset,
  input  logic             en_i,
  input  logic             run_i,
  input  logic             load_i,
  input  logic             capture_i,
  input  logic [CMD_W-1:0] cmd_i,
  input  logic             miso_i,
  output logic             half_end_c_o,
  output logic             fall_c_o,
  output logic             sclk_o,
  output logic             mosi_o,
  output logic [BUF_W-1:0] rd_data_o
);

  localparam int unsigned DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

  logic [DIV_W-1:0] div_q, div_d;
  logic             sclk_q, sclk_d;
  logic [CMD_W-1:0] sh_q, sh_d;
  logic [BUF_W-1:0] rd_q, rd_d;
  logic             half_end_c, rise_c, fall_c;

  // The SCLK level itself tells which half-period is ending
  always_comb begin
    half_end_c = en_i && (div_q == DIV_W'(CLK_DIV - 1));
    rise_c     = run_i && half_end_c && !sclk_q;
    fall_c     = run_i && half_end_c && sclk_q;
  end

  always_comb begin
    div_d  = div_q;
    sclk_d = sclk_q;
    sh_d   = sh_q;
    rd_d   = rd_q;
    if (!en_i || half_end_c) begin
      div_d = '0;
    end else begin
      div_d = div_q + DIV_W'(1);
    end
    if (rise_c) begin
      sclk_d = 1'b1;
      if (capture_i) begin
        rd_d = {rd_q[BUF_W-2:0], miso_i};
      end
    end
    if (fall_c) begin
      sclk_d = 1'b0;
      sh_d   = {sh_q[CMD_W-2:0], MOSI_IDLE};
    end
    if (load_i) begin
      div_d  = '0;
      sclk_d = SCLK_IDLE;
      sh_d   = cmd_i;
      rd_d   = '0;
    end
  end

  always_ff @(posedge m_clk) begin
    if (!n_reset) begin
      div_q  <= '0;
      sclk_q <= SCLK_IDLE;
      sh_q   <= '0;
      rd_q   <= '0;
    end else begin
      div_q  <= div_d;
      sclk_q <= sclk_d;
      sh_q   <= sh_d;
      rd_q   <= rd_d;
    end
  end

  assign half_end_c_o = half_end_c;
  assign fall_c_o     = fall_c;
  assign sclk_o       = sclk_q;
  assign mosi_o       = sh_q[CMD_W-1];
  assign rd_data_o    = rd_q;

endmodule

// File: rtl/spi_txn_scheduler.sv
// Round-robin owner of one SPI master link: arbitration, transaction FSM and grant/done.
module spi_txn_scheduler
  import spi_ctrl_pkg::*;
#(
  parameter int unsigned N_REQ   = 2,
  parameter int unsigned CLK_DIV = 10
) (
  input  logic                   m_clk,
  input  logic                   n_reset,
  input  logic [N_REQ-1:0]       req,
  input  logic [CMD_W*N_REQ-1:0] req_cmd,
  input  logic [LEN_W*N_REQ-1:0] req_len,
  output logic [N_REQ-1:0]       grant,
  output logic [N_REQ-1:0]       done,
  output logic [BUF_W-1:0]       rd_data,
  output logic                   busy,
  output logic                   spi_sclk_out,
  output logic                   spi_cs_n_out,
  output logic                   spi_mosi_out,
  input  logic                   spi_miso_in
);

  localparam int unsigned PTR_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;

  state_e               state_q, state_d;
  logic [PTR_W-1:0]     ptr_q, ptr_d, win_c;
  logic                 any_c;
  txn_t                 txn_c;
  logic [N_REQ-1:0]     grant_q, grant_d, done_q, done_d;
  logic                 busy_q, busy_d, cs_n_q, cs_n_d;
  logic [LEN_W-1:0]     len_q, len_d;
  logic [BIT_CNT_W-1:0] bit_cnt_q, bit_cnt_d, last_bit_c;
  logic                 load_c, half_end_c, fall_c;

  // First set request strictly after the last owner, wrapping around
  always_comb begin
    any_c = 1'b0;
    win_c = '0;
    txn_c = '0;
    for (int unsigned k = 1; k <= N_REQ; k++) begin
      for (int unsigned i = 0; i < N_REQ; i++) begin
        if (!any_c && req[i] && (((32'(ptr_q) + k) % N_REQ) == i)) begin
          any_c = 1'b1;
          win_c = PTR_W'(i);
        end
      end
    end
    for (int unsigned i = 0; i < N_REQ; i++) begin
      if (win_c == PTR_W'(i)) begin
        txn_c.cmd = req_cmd[CMD_W*i +: CMD_W];
        txn_c.len = req_len[LEN_W*i +: LEN_W];
      end
    end
  end

  // Index of the final falling edge: 8 command bits plus 8*len data bits
  assign last_bit_c = {len_q, 3'b111};

  always_comb begin
    state_d   = state_q;
    ptr_d     = ptr_q;
    grant_d   = grant_q;
    done_d    = '0;
    busy_d    = busy_q;
    cs_n_d    = cs_n_q;
    len_d     = len_q;
    bit_cnt_d = bit_cnt_q;
    load_c    = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (any_c) begin
          state_d   = ST_SETUP;
          ptr_d     = win_c;
          grant_d   = N_REQ'(1) << win_c;
          busy_d    = 1'b1;
          cs_n_d    = 1'b0;
          len_d     = txn_c.len;
          bit_cnt_d = '0;
          load_c    = 1'b1;
        end
      end
      ST_SETUP: begin
        if (half_end_c) state_d = ST_CMD;
      end
      ST_CMD: begin
        if (fall_c) begin
          bit_cnt_d = bit_cnt_q + BIT_CNT_W'(1);
          if (bit_cnt_q == BIT_CNT_W'(CMD_W - 1)) begin
            state_d = (len_q == '0) ? ST_HOLD : ST_DATA;
          end
        end
      end
      ST_DATA: begin
        if (fall_c) begin
          bit_cnt_d = bit_cnt_q + BIT_CNT_W'(1);
          if (bit_cnt_q == last_bit_c) state_d = ST_HOLD;
        end
      end
      ST_HOLD: begin
        if (half_end_c) begin
          state_d = ST_GAP;
          cs_n_d  = CS_N_IDLE;
          done_d  = grant_q;
          grant_d = '0;
          busy_d  = 1'b0;
        end
      end
      ST_GAP: begin
        if (half_end_c) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Reset also aborts any transaction in flight without a done pulse
  always_ff @(posedge m_clk) begin
    if (!n_reset) begin
      state_q   <= ST_IDLE;
      ptr_q     <= PTR_W'(N_REQ - 1);
      grant_q   <= '0;
      done_q    <= '0;
      busy_q    <= 1'b0;
      cs_n_q    <= CS_N_IDLE;
      len_q     <= '0;
      bit_cnt_q <= '0;
    end else begin
      state_q   <= state_d;
      ptr_q     <= ptr_d;
      grant_q   <= grant_d;
      done_q    <= done_d;
      busy_q    <= busy_d;
      cs_n_q    <= cs_n_d;
      len_q     <= len_d;
      bit_cnt_q <= bit_cnt_d;
    end
  end

  spi_bit_engine #(
    .CLK_DIV (CLK_DIV)
  ) u_bit_engine (
    .m_clk        (m_clk),
    .n_reset      (n_reset),
    .en_i         (state_q != ST_IDLE),
    .run_i        ((state_q == ST_CMD) || (state_q == ST_DATA)),
    .load_i       (load_c),
    .capture_i    (state_q == ST_DATA),
    .cmd_i        (txn_c.cmd),
    .miso_i       (spi_miso_in),
    .half_end_c_o (half_end_c),
    .fall_c_o     (fall_c),
    .sclk_o       (spi_sclk_out),
    .mosi_o       (spi_mosi_out),
    .rd_data_o    (rd_data)
  );

  assign grant        = grant_q;
  assign done         = done_q;
  assign busy         = busy_q;
  assign spi_cs_n_out = cs_n_q;

endmodule

// File: tb/tb_spi_txn_scheduler.sv
// Directed bench for spi_txn_scheduler with a mode-0 SPI slave model.
module tb_spi_txn_scheduler;

  logic         m_clk = 1'b0;
  logic         n_reset = 1'b0;
  logic [1:0]   req;
  logic [15:0]  req_cmd;
  logic [7:0]   req_len;
  logic [1:0]   grant, done;
  logic [119:0] rd_data;
  logic         busy, spi_sclk_out, spi_cs_n_out, spi_mosi_out, spi_miso_in;

  int           n_tests = 0;
  int           n_fail = 0;
  int           cyc = 0;
  int           sclk_cnt = 0;
  logic [127:0] mosi_cap = '0;
  logic [127:0] sl_resp = '0;

  spi_txn_scheduler #(.N_REQ(2), .CLK_DIV(10)) dut (
    .m_clk        (m_clk),
    .n_reset      (n_reset),
    .req          (req),
    .req_cmd      (req_cmd),
    .req_len      (req_len),
    .grant        (grant),
    .done         (done),
    .rd_data      (rd_data),
    .busy         (busy),
    .spi_sclk_out (spi_sclk_out),
    .spi_cs_n_out (spi_cs_n_out),
    .spi_mosi_out (spi_mosi_out),
    .spi_miso_in  (spi_miso_in)
  );

  always #5 m_clk = ~m_clk;
  always @(posedge m_clk) cyc <= cyc + 1;

  // SCLK pulse counter and MOSI capture, restarted when cs_n falls
  always @(posedge spi_sclk_out or negedge spi_cs_n_out) begin
    if (spi_sclk_out) begin
      sclk_cnt <= sclk_cnt + 1;
      mosi_cap <= {mosi_cap[126:0], spi_mosi_out};
    end else begin
      sclk_cnt <= 0;
      mosi_cap <= '0;
    end
  end

  // Slave presents sl_resp MSB first; bit k is held until rise k has happened
  assign spi_miso_in = (sclk_cnt < 128) ? sl_resp[127 - sclk_cnt] : 1'b0;

  task automatic check_eq(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic start_txn(input int r, input logic [7:0] cmd, input logic [3:0] len,
                           input logic [127:0] resp);
    req_cmd[8*r +: 8] = cmd;
    req_len[4*r +: 4] = len;
    sl_resp           = resp;
    req[r]            = 1'b1;
  endtask

  task automatic wait_grant(input string tag, output int g, output logic [1:0] gv);
    logic hit = 1'b0;
    g  = cyc;
    gv = '0;
    for (int i = 0; i < 5000; i++) begin
      @(negedge m_clk);
      if (|grant) begin
        hit = 1'b1;
        g   = cyc;
        gv  = grant;
        break;
      end
    end
    check_eq(tag, 128'(hit), 128'(1));
  endtask

  task automatic wait_done(input string tag, output int d, output logic [1:0] dv);
    logic hit = 1'b0;
    d  = cyc;
    dv = '0;
    for (int i = 0; i < 5000; i++) begin
      @(negedge m_clk);
      if (|done) begin
        hit = 1'b1;
        d   = cyc;
        dv  = done;
        break;
      end
    end
    check_eq(tag, 128'(hit), 128'(1));
  endtask

  initial begin
    int         g, d, d_prev;
    logic [1:0] gv, dv;
    logic       hit;

    req = '0; req_cmd = '0; req_len = '0;
    repeat (3) @(negedge m_clk);
    check_eq("rst_grant", 128'(grant), 128'(0));
    check_eq("rst_done", 128'(done), 128'(0));
    check_eq("rst_busy", 128'(busy), 128'(0));
    check_eq("rst_rd", 128'(rd_data), 128'(0));
    check_eq("rst_pins", 128'({spi_sclk_out, spi_cs_n_out, spi_mosi_out}), 128'(3'b010));
    n_reset = 1'b1;

    // Read of one byte
    start_txn(0, 8'h03, 4'd1, {8'h00, 8'hA5, 112'h0});
    wait_grant("t1_grant_to", g, gv);
    check_eq("t1_grant", 128'(gv), 128'(2'b01));
    check_eq("t1_busy", 128'(busy), 128'(1));
    check_eq("t1_cs", 128'(spi_cs_n_out), 128'(0));
    req = '0;
    wait_done("t1_done_to", d, dv);
    check_eq("t1_done", 128'(dv), 128'(2'b01));
    check_eq("t1_dur", 128'(d - g), 128'(340));
    check_eq("t1_rd", 128'(rd_data), 128'(8'hA5));
    check_eq("t1_sclk", 128'(sclk_cnt), 128'(16));
    check_eq("t1_mosi", 128'(mosi_cap[15:0]), 128'(16'h0300));
    check_eq("t1_idle", 128'({grant, busy, spi_cs_n_out}), 128'(4'b0001));
    @(negedge m_clk);
    check_eq("t1_pulse", 128'(done), 128'(0));

    // Maximum-length read from requester 1
    start_txn(1, 8'h9F, 4'd15, {8'h00, 120'h0102030405060708090A0B0C0D0E0F});
    wait_grant("t2_grant_to", g, gv);
    check_eq("t2_grant", 128'(gv), 128'(2'b10));
    req = '0;
    wait_done("t2_done_to", d, dv);
    check_eq("t2_done", 128'(dv), 128'(2'b10));
    check_eq("t2_dur", 128'(d - g), 128'(2580));
    check_eq("t2_sclk", 128'(sclk_cnt), 128'(128));
    check_eq("t2_rd", 128'(rd_data), 128'(120'h0102030405060708090A0B0C0D0E0F));
    check_eq("t2_mosi", mosi_cap, {8'h9F, 120'h0});

    // Both requesting: strict alternation with a deselect gap in between
    req_len = '0;
    sl_resp = '0;
    req     = 2'b11;
    d_prev  = 0;
    for (int t = 0; t < 4; t++) begin
      wait_grant("t3_grant_to", g, gv);
      check_eq($sformatf("t3_grant%0d", t), 128'(gv), (t % 2 == 0) ? 128'(2'b01) : 128'(2'b10));
      if (t > 0) check_eq($sformatf("t3_gap%0d", t), 128'(g - d_prev), 128'(11));
      if (t == 3) req = '0;
      wait_done("t3_done_to", d, dv);
      check_eq($sformatf("t3_done%0d", t), 128'(dv), 128'(gv));
      check_eq($sformatf("t3_cs%0d", t), 128'(spi_cs_n_out), 128'(1));
      d_prev = d;
    end

    // Command only
    start_txn(0, 8'hAB, 4'd0, '0);
    wait_grant("t4_grant_to", g, gv);
    req = '0;
    wait_done("t4_done_to", d, dv);
    check_eq("t4_dur", 128'(d - g), 128'(180));
    check_eq("t4_sclk", 128'(sclk_cnt), 128'(8));
    check_eq("t4_mosi", 128'(mosi_cap[7:0]), 128'(8'hAB));
    check_eq("t4_rd", 128'(rd_data), 128'(0));

    // Reset in the middle of the data phase
    start_txn(0, 8'h3B, 4'd3, {8'h00, 24'hC3A55A, 96'h0});
    wait_grant("t5_grant_to", g, gv);
    check_eq("t5_grant", 128'(gv), 128'(2'b01));
    req = 2'b11;
    req_cmd[15:8] = 8'h11;
    hit = 1'b0;
    for (int i = 0; i < 2000; i++) begin
      @(negedge m_clk);
      if (sclk_cnt == 28) begin
        hit = 1'b1;
        break;
      end
    end
    check_eq("t5_bit20_to", 128'(hit), 128'(1));
    check_eq("t5_rd_pre", 128'(rd_data), 128'(20'hC3A55));
    n_reset = 1'b0;
    @(negedge m_clk);
    check_eq("t5_abort_pins", 128'({spi_cs_n_out, spi_sclk_out}), 128'(2'b10));
    check_eq("t5_abort_ctl", 128'({grant, busy, done}), 128'(0));
    check_eq("t5_abort_rd", 128'(rd_data), 128'(0));
    @(negedge m_clk);
    check_eq("t5_no_done", 128'(done), 128'(0));
    n_reset = 1'b1;
    wait_grant("t5_regrant_to", g, gv);
    check_eq("t5_regrant", 128'(gv), 128'(2'b01));
    req = '0;
    wait_done("t5_done_to", d, dv);
    check_eq("t5_done", 128'(dv), 128'(2'b01));
    check_eq("t5_dur", 128'(d - g), 128'(660));
    check_eq("t5_rd", 128'(rd_data), 128'(24'hC3A55A));

    // Request withdrawn and command changed after grant
    start_txn(0, 8'h5A, 4'd1, {8'h00, 8'h3C, 112'h0});
    wait_grant("t6_grant_to", g, gv);
    req = '0;
    req_cmd[7:0] = 8'hFF;
    wait_done("t6_done_to", d, dv);
    check_eq("t6_done", 128'(dv), 128'(2'b01));
    check_eq("t6_dur", 128'(d - g), 128'(340));
    check_eq("t6_mosi", 128'(mosi_cap[15:0]), 128'(16'h5A00));
    check_eq("t6_rd", 128'(rd_data), 128'(8'h3C));
    repeat (5) @(negedge m_clk);
    check_eq("t6_rd_hold", 128'(rd_data), 128'(8'h3C));

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
